// File: rtl/spi_receiver.sv
// Slave-side SPI frame receiver: oversamples spi_clock/cs_n/spi_data in the clk
// domain, collects DATA_WIDTH bits per cs_n-low window, presents words on valid/ready.
module spi_receiver #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_clock,
  input  logic                  spi_data,
  input  logic                  cs_n,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_error,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned CNT_W   = $clog2(DATA_WIDTH + 1);
  localparam int unsigned FLUSH   = SYNC_STAGES + 2;
  localparam int unsigned FLUSH_W = $clog2(FLUSH + 1);

  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]   CNT_SAT   = CNT_W'(DATA_WIDTH + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_MAX = FLUSH_W'(FLUSH);

  localparam logic [1:0] ST_ARM   = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  // Top bit of the cs_n/spi_clock chains is the edge-detect history flop.
  logic [SYNC_STAGES:0]   cs_sync;
  logic [SYNC_STAGES:0]   sck_sync;
  logic [SYNC_STAGES-1:0] sd_sync;

  logic cs_cur, cs_hist, sck_cur, sck_hist;

  logic sample_q, bit_q, cs_fall_q, cs_rise_q, cs_lvl_q;

  logic [1:0]            state;
  logic [FLUSH_W-1:0]    flush;
  logic [DATA_WIDTH-1:0] sr, sr_next;
  logic [CNT_W-1:0]      cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      sd_sync  <= '1;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-1:0], cs_n};
      sck_sync <= {sck_sync[SYNC_STAGES-1:0], spi_clock};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], spi_data};
    end
  end

  assign cs_cur   = cs_sync[SYNC_STAGES-1];
  assign cs_hist  = cs_sync[SYNC_STAGES];
  assign sck_cur  = sck_sync[SYNC_STAGES-1];
  assign sck_hist = sck_sync[SYNC_STAGES];

  // Edge events are registered once so data bit, sample strobe and cs_n edges
  // reach the state machine in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q  <= 1'b0;
      bit_q     <= 1'b1;
      cs_fall_q <= 1'b0;
      cs_rise_q <= 1'b0;
      cs_lvl_q  <= 1'b1;
    end else begin
      sample_q  <= sck_hist & ~sck_cur;
      bit_q     <= sd_sync[SYNC_STAGES-1];
      cs_fall_q <= cs_hist & ~cs_cur;
      cs_rise_q <= ~cs_hist & cs_cur;
      cs_lvl_q  <= cs_cur;
    end
  end

  // A sample coinciding with the cs_n rise is folded in before evaluation.
  always_comb begin
    sr_next  = sr;
    cnt_next = cnt;
    if (sample_q) begin
      sr_next  = {sr[DATA_WIDTH-2:0], bit_q};
      cnt_next = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ARM;
      flush       <= '0;
      sr          <= '0;
      cnt         <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      case (state)
        // Chains hold reset values until flushed; only trust cs_n after that.
        ST_ARM: begin
          if (flush != FLUSH_MAX) begin
            flush <= flush + FLUSH_W'(1);
          end else if (cs_lvl_q) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (cs_fall_q) begin
            sr    <= '0;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt_next;
          if (cs_rise_q) begin
            state <= ST_IDLE;
            if (cnt_next == CNT_FULL) begin
              data_out   <= sr_next;
              data_valid <= 1'b1;
              overrun    <= data_valid && !data_ready;
            end else begin
              frame_error <= 1'b1;
            end
          end
        end
        default: state <= ST_ARM;
      endcase
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule
